dlx_dual_port_mem: RTL
======================

Name: dlx_dual_port_mem

Overview:
Parametrised two-channel memory model for the DLX bench and for FPGA prototyping.
- Channel RO: read-only, serves instruction fetch.
- Channel RW: read/write with byte enables, serves load/store.
- Each channel has its own programmable wait-state latency and a one-cycle DATA_READY completion pulse, so the core's stall logic sees realistic memory timing.
- Replaces the fixed single-port memory models. The bidirectional data bus is split into separate write and read buses.

Parameters:
ADDRESS_SIZE, 16, byte address width on both channels.
WORD_SIZE, 32, data word width in bits; must be a multiple of 8.
DEPTH, 1024, number of words; must be a power of two, and DEPTH*WORD_SIZE/8 must not exceed 2**ADDRESS_SIZE.
RO_LATENCY, 1, cycles from request acceptance to DATA_READY_RO; minimum 1.
RW_LATENCY, 2, cycles from request acceptance to DATA_READY_RW; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
ENABLE_RO  input  1  RO request strobe.
ADDRESS_RO  input  ADDRESS_SIZE  RO byte address.
DATA_RO  output  WORD_SIZE  RO read data.
DATA_READY_RO  output  1  RO completion pulse.
ENABLE_RW  input  1  RW request strobe.
READNOTWRITE  input  1  RW direction: 1 = read, 0 = write.
ADDRESS_RW  input  ADDRESS_SIZE  RW byte address.
WDATA_RW  input  WORD_SIZE  RW write data.
BE_RW  input  WORD_SIZE/8  RW byte enables; bit i covers byte i.
RDATA_RW  output  WORD_SIZE  RW read data.
DATA_READY_RW  output  1  RW completion pulse.
ERR_RO  output  1  RO access error; present only with the optional feature.
ERR_RW  output  1  RW access error; present only with the optional feature.

Behaviour:
Reset:
- All outputs are 0 one edge after rst is sampled high.
- Both channel FSMs go to IDLE and latency counters clear.
- Array contents are not cleared.
- rst has priority over ENABLE on the same edge.
- A pending access is aborted, and an aborted write is never committed.

Per-channel FSM (IDLE, BUSY):
- IDLE, ENABLE sampled high at edge n: capture address (plus direction, write data and BE on RW). Go to BUSY with cnt = L-1, where L is the channel latency.
- IDLE, ENABLE low: stay IDLE.
- BUSY, cnt != 0: decrement. ENABLE is ignored, with no queuing.
- BUSY, cnt == 0, at edge n+L: perform the access, drive DATA_READY = 1 for exactly one cycle, return to IDLE.

Timing and data:
- A request may be accepted during the cycle DATA_READY is high, i.e. back-to-back.
- Peak throughput is one access per L+1 cycles per channel.
- Read data is registered at completion and holds until the next completed read on that channel.
- RW write updates only bytes with BE_RW[i] = 1, pulses DATA_READY_RW, and leaves RDATA_RW unchanged.
- BE_RW = 0 completes normally with no array change.
- Word index = ADDRESS >> log2(WORD_SIZE/8).

Simultaneous events:
- RO read and RW write to the same word completing on the same edge: RO returns the old data (read-before-write).
- Both channels are otherwise fully independent.

Optional Feature:
Macro: DLX_MEM_ERR_CHECK_EN.
- Defined: ERR_RO and ERR_RW ports exist. An access is in error if its byte address is misaligned (low log2(WORD_SIZE/8) bits nonzero) or its word index is >= DEPTH.
- Error handling: the access is not performed, read data is driven to 0, and ERR pulses high in the same cycle as DATA_READY. Latency is unchanged.
- Not defined: no ERR ports; the low address bits are ignored and the word index wraps modulo DEPTH.

Test Plan:
- Reset, then RO read of preloaded word 0x0000_0010 = 0xDEADBEEF with RO_LATENCY=1 -> DATA_READY_RO high exactly 1 cycle after acceptance, DATA_RO = 0xDEADBEEF; with RO_LATENCY=4, ready 4 cycles after acceptance.
- RW write 0x11223344 to 0x0020 with BE=0b0101 over old value 0xAABBCCDD, then read 0x0020 -> RDATA_RW = 0xAA22CC44; write completion does not change RDATA_RW.
- ENABLE_RW held high for 10 cycles with RW_LATENCY=2 -> accepts at cycles 0, 3, 6, 9; DATA_READY_RW pulses at cycles 2, 5, 8; requests during BUSY are ignored.
- RO read and RW write to the same word completing on the same edge -> DATA_RO returns the pre-write value; a subsequent RO read returns the new value.
- rst asserted mid-write (cnt != 0) -> no DATA_READY pulse, word unchanged, all outputs 0 next cycle, new request accepted the cycle after rst drops.
- With DLX_MEM_ERR_CHECK_EN: RO read at 0x0002, and RW read at DEPTH*4 -> ERR plus DATA_READY pulse, data 0. Without the macro, 0x0002 reads word 0 and DEPTH*4 wraps to word 0.

Source files
------------

// File: rtl/dlx_dual_port_mem.sv
// Two-channel DLX memory model: read-only fetch channel and byte-enabled load/store channel,
// each with its own wait-state latency. Define DLX_MEM_ERR_CHECK_EN to add ERR_RO/ERR_RW access checking.
module dlx_dual_port_mem #(
  parameter int unsigned ADDRESS_SIZE = 16,
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned RO_LATENCY   = 1,
  parameter int unsigned RW_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ENABLE_RO,
  input  logic [ADDRESS_SIZE-1:0]   ADDRESS_RO,
  output logic [WORD_SIZE-1:0]      DATA_RO,
  output logic                      DATA_READY_RO,
  input  logic                      ENABLE_RW,
  input  logic                      READNOTWRITE,
  input  logic [ADDRESS_SIZE-1:0]   ADDRESS_RW,
  input  logic [WORD_SIZE-1:0]      WDATA_RW,
  input  logic [WORD_SIZE/8-1:0]    BE_RW,
  output logic [WORD_SIZE-1:0]      RDATA_RW,
  output logic                      DATA_READY_RW
`ifdef DLX_MEM_ERR_CHECK_EN
  , output logic                    ERR_RO
  , output logic                    ERR_RW
`endif
);

  localparam int unsigned BYTES = WORD_SIZE / 8;
  localparam int unsigned OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RO_CW = (RO_LATENCY > 1) ? $clog2(RO_LATENCY) : 1;
  localparam int unsigned RW_CW = (RW_LATENCY > 1) ? $clog2(RW_LATENCY) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  state_t                  ro_state, ro_state_n;
  logic [RO_CW-1:0]        ro_cnt, ro_cnt_n;
  logic [ADDRESS_SIZE-1:0] ro_addr, ro_addr_n;
  logic                    ro_done_c, ro_err_c;
  logic [IDX_W-1:0]        ro_idx_c;

  state_t                  rw_state, rw_state_n;
  logic [RW_CW-1:0]        rw_cnt, rw_cnt_n;
  logic [ADDRESS_SIZE-1:0] rw_addr, rw_addr_n;
  logic                    rw_rnw, rw_rnw_n;
  logic [WORD_SIZE-1:0]    rw_wdata, rw_wdata_n;
  logic [BYTES-1:0]        rw_be, rw_be_n;
  logic                    rw_done_c, rw_err_c;
  logic [IDX_W-1:0]        rw_idx_c;
  logic [WORD_SIZE-1:0]    rw_old_c, rw_merged_c;

  assign ro_idx_c = IDX_W'(ro_addr >> OFFS);
  assign rw_idx_c = IDX_W'(rw_addr >> OFFS);

`ifdef DLX_MEM_ERR_CHECK_EN
  // Misaligned byte address or word index beyond DEPTH
  function automatic logic addr_err(input logic [ADDRESS_SIZE-1:0] a);
    return ((a & ADDRESS_SIZE'(BYTES - 1)) != '0) || ((a >> (OFFS + IDX_W)) != '0);
  endfunction
  assign ro_err_c = addr_err(ro_addr);
  assign rw_err_c = addr_err(rw_addr);
`else
  // Low offset bits and bits above the index are intentionally dropped (wrap modulo DEPTH)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ro_addr, rw_addr};
  assign ro_err_c = 1'b0;
  assign rw_err_c = 1'b0;
`endif

  // RO channel next-state
  always_comb begin
    ro_state_n = ro_state;
    ro_cnt_n   = ro_cnt;
    ro_addr_n  = ro_addr;
    ro_done_c  = 1'b0;
    case (ro_state)
      IDLE: if (ENABLE_RO) begin
        ro_state_n = BUSY;
        ro_cnt_n   = RO_CW'(RO_LATENCY - 1);
        ro_addr_n  = ADDRESS_RO;
      end
      BUSY: if (ro_cnt != '0) begin
        ro_cnt_n = ro_cnt - RO_CW'(1);
      end else begin
        ro_done_c  = 1'b1;
        ro_state_n = IDLE;
      end
      default: ro_state_n = IDLE;
    endcase
  end

  // RW channel next-state
  always_comb begin
    rw_state_n = rw_state;
    rw_cnt_n   = rw_cnt;
    rw_addr_n  = rw_addr;
    rw_rnw_n   = rw_rnw;
    rw_wdata_n = rw_wdata;
    rw_be_n    = rw_be;
    rw_done_c  = 1'b0;
    case (rw_state)
      IDLE: if (ENABLE_RW) begin
        rw_state_n = BUSY;
        rw_cnt_n   = RW_CW'(RW_LATENCY - 1);
        rw_addr_n  = ADDRESS_RW;
        rw_rnw_n   = READNOTWRITE;
        rw_wdata_n = WDATA_RW;
        rw_be_n    = BE_RW;
      end
      BUSY: if (rw_cnt != '0) begin
        rw_cnt_n = rw_cnt - RW_CW'(1);
      end else begin
        rw_done_c  = 1'b1;
        rw_state_n = IDLE;
      end
      default: rw_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ro_state      <= IDLE;
      ro_cnt        <= '0;
      ro_addr       <= '0;
      DATA_RO       <= '0;
      DATA_READY_RO <= 1'b0;
`ifdef DLX_MEM_ERR_CHECK_EN
      ERR_RO        <= 1'b0;
`endif
    end else begin
      ro_state      <= ro_state_n;
      ro_cnt        <= ro_cnt_n;
      ro_addr       <= ro_addr_n;
      DATA_READY_RO <= ro_done_c;
      if (ro_done_c) DATA_RO <= ro_err_c ? '0 : mem[ro_idx_c];
`ifdef DLX_MEM_ERR_CHECK_EN
      ERR_RO        <= ro_done_c & ro_err_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_state      <= IDLE;
      rw_cnt        <= '0;
      rw_addr       <= '0;
      rw_rnw        <= 1'b0;
      rw_wdata      <= '0;
      rw_be         <= '0;
      RDATA_RW      <= '0;
      DATA_READY_RW <= 1'b0;
`ifdef DLX_MEM_ERR_CHECK_EN
      ERR_RW        <= 1'b0;
`endif
    end else begin
      rw_state      <= rw_state_n;
      rw_cnt        <= rw_cnt_n;
      rw_addr       <= rw_addr_n;
      rw_rnw        <= rw_rnw_n;
      rw_wdata      <= rw_wdata_n;
      rw_be         <= rw_be_n;
      DATA_READY_RW <= rw_done_c;
      if (rw_done_c && rw_rnw) RDATA_RW <= rw_err_c ? '0 : rw_old_c;
`ifdef DLX_MEM_ERR_CHECK_EN
      ERR_RW        <= rw_done_c & rw_err_c;
`endif
    end
  end

  // Byte-enable merge of write data over the current word
  assign rw_old_c = mem[rw_idx_c];
  for (genvar b = 0; b < BYTES; b++) begin : g_be
    assign rw_merged_c[8*b +: 8] = rw_be[b] ? rw_wdata[8*b +: 8] : rw_old_c[8*b +: 8];
  end

  // Array is never reset; an aborted write is blocked by rst
  always_ff @(posedge clk) begin
    if (!rst && rw_done_c && !rw_rnw && !rw_err_c) mem[rw_idx_c] <= rw_merged_c;
  end

endmodule
